// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard/stall controller (slave).
// StallCnt_o is present only when HAZARD_STALL_CNT_EN is defined.
interface hazard_stall_ctrl_if;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RegDst_i;
  logic [4:0]  IFID_RS1_i;
  logic [4:0]  IFID_RS2_i;
  logic        MemStall_i;
  logic        BranchTaken_i;
  logic        Hazard_o;
  logic        PCWrite_o;
  logic        IFIDWrite_o;
  logic        IFIDFlush_o;
  logic        Freeze_o;
  logic        MemErr_o;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] StallCnt_o;
`endif

  modport master (
`ifdef HAZARD_STALL_CNT_EN
    input  StallCnt_o,
`endif
    output IDEX_MemRead_i, IDEX_RegDst_i, IFID_RS1_i, IFID_RS2_i, MemStall_i, BranchTaken_i,
    input  Hazard_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, Freeze_o, MemErr_o
  );

  modport slave (
`ifdef HAZARD_STALL_CNT_EN
    output StallCnt_o,
`endif
    input  IDEX_MemRead_i, IDEX_RegDst_i, IFID_RS1_i, IFID_RS2_i, MemStall_i, BranchTaken_i,
    output Hazard_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, Freeze_o, MemErr_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubble, branch flush, memory-wait freeze with timeout.
// Optional stall-cycle counter (StallCnt_o) enabled by defining HAZARD_STALL_CNT_EN.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_stall_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             mem_err, timeout;
  logic             lu, lu_act;
  logic             hazard, pc_write, ifid_write, ifid_flush, freeze;

  assign lu = bus.IDEX_MemRead_i && (bus.IDEX_RegDst_i != 5'd0) &&
              ((bus.IDEX_RegDst_i == bus.IFID_RS1_i) || (bus.IDEX_RegDst_i == bus.IFID_RS2_i));
  // The bubble for this load is already in EX while in LU_HOLD, so a second one is suppressed.
  assign lu_act = lu && (state != LU_HOLD);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout) mem_err <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    state_next    = RUN;
    wait_cnt_next = '0;
    timeout       = 1'b0;
    if (bus.MemStall_i) begin
      if (state != MEM_WAIT) begin
        state_next    = MEM_WAIT;
        wait_cnt_next = CNT_W'(1);
      end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
        timeout = 1'b1;
      end else begin
        state_next    = MEM_WAIT;
        wait_cnt_next = wait_cnt + CNT_W'(1);
      end
    end else if (!bus.BranchTaken_i && lu_act) begin
      state_next = LU_HOLD;
    end
  end

  // Mealy outputs: a MEM_WAIT cycle without MemStall_i resolves exactly like RUN.
  always_comb begin
    hazard     = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    freeze     = 1'b0;
    if (!rst_i) begin
      hazard     = 1'b1;
      ifid_flush = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (bus.MemStall_i) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (bus.BranchTaken_i) begin
      ifid_flush = 1'b1;
    end else if (lu_act) begin
      hazard     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  assign bus.Hazard_o    = hazard;
  assign bus.PCWrite_o   = pc_write;
  assign bus.IFIDWrite_o = ifid_write;
  assign bus.IFIDFlush_o = ifid_flush;
  assign bus.Freeze_o    = freeze;
  assign bus.MemErr_o    = mem_err;

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (!pc_write && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.StallCnt_o = stall_cnt;
`endif

endmodule
